// File: rtl/mc_controller_if.sv
// Decode inputs and datapath controls exchanged between the multi-cycle controller and the datapath.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [3:0] alu_control;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_control, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_control, instr_done, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle RV32I-subset control unit: Moore FSM with registered datapath controls,
// ALU operation decode and branch resolution from the ALU zero flag.
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master ctrl
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_LESS = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    state_t     state_reg, state_next, load_state;
    logic       decode_illegal_next;
    logic [3:0] r_alu_next, i_alu_next;
    logic       r_illegal_next, i_illegal_next;

    logic       pc_write_reg, adr_src_reg, mem_write_reg, ir_write_reg;
    logic       reg_write_reg, instr_done_reg, branch_reg;
    logic [1:0] result_src_reg, alu_src_a_reg, alu_src_b_reg;
    logic [3:0] alu_control_reg;

    always_comb begin
        r_alu_next = ALU_ADD;
        case (ctrl.funct3)
            3'b000:         r_alu_next = ctrl.funct7b5 ? ALU_SUB : ALU_ADD;
            3'b001:         r_alu_next = ALU_SLL;
            3'b010, 3'b011: r_alu_next = ALU_LESS;
            3'b100:         r_alu_next = ALU_XOR;
            3'b101:         r_alu_next = ctrl.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:         r_alu_next = ALU_OR;
            3'b111:         r_alu_next = ALU_AND;
            default:        r_alu_next = ALU_ADD;
        endcase
        // Immediate forms never subtract, so funct7b5 only matters for the shift pair.
        i_alu_next     = (ctrl.funct3 == 3'b000) ? ALU_ADD : r_alu_next;
        r_illegal_next = ctrl.funct7b5 && (ctrl.funct3 != 3'b000) && (ctrl.funct3 != 3'b101);
        i_illegal_next = ctrl.funct7b5 && (ctrl.funct3 == 3'b001);
    end

    always_comb begin
        state_next          = S_FETCH;
        decode_illegal_next = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R: begin
                        decode_illegal_next = r_illegal_next;
                        state_next          = r_illegal_next ? S_FETCH : S_EXECR;
                    end
                    OP_I: begin
                        decode_illegal_next = i_illegal_next;
                        state_next          = i_illegal_next ? S_FETCH : S_EXECI;
                    end
                    OP_BR: begin
                        decode_illegal_next = (ctrl.funct3[2:1] != 2'b00);
                        state_next          = decode_illegal_next ? S_FETCH : S_BRANCH;
                    end
                    OP_JAL:  state_next = S_JAL;
                    default: decode_illegal_next = 1'b1;
                endcase
            end
            S_MEMADR:                 state_next = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:                state_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL:  state_next = S_ALUWB;
            default:                  state_next = S_FETCH;
        endcase
    end

    // Controls are registered against the state being entered, so reset preloads FETCH's set.
    assign load_state = reset ? S_FETCH : state_next;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;

        pc_write_reg    <= 1'b0;
        adr_src_reg     <= 1'b0;
        mem_write_reg   <= 1'b0;
        ir_write_reg    <= 1'b0;
        reg_write_reg   <= 1'b0;
        instr_done_reg  <= 1'b0;
        branch_reg      <= 1'b0;
        result_src_reg  <= 2'b00;
        alu_src_a_reg   <= 2'b00;
        alu_src_b_reg   <= 2'b00;
        alu_control_reg <= ALU_ADD;
        case (load_state)
            S_FETCH: begin
                ir_write_reg   <= 1'b1;
                pc_write_reg   <= 1'b1;
                alu_src_b_reg  <= 2'b10;
                result_src_reg <= 2'b10;
            end
            S_DECODE: begin
                alu_src_a_reg <= 2'b01;
                alu_src_b_reg <= 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_reg <= 2'b10;
                alu_src_b_reg <= 2'b01;
            end
            S_MEMREAD: adr_src_reg <= 1'b1;
            S_MEMWB: begin
                result_src_reg <= 2'b01;
                reg_write_reg  <= 1'b1;
                instr_done_reg <= 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_reg    <= 1'b1;
                mem_write_reg  <= 1'b1;
                instr_done_reg <= 1'b1;
            end
            S_EXECR: begin
                alu_src_a_reg   <= 2'b10;
                alu_control_reg <= r_alu_next;
            end
            S_EXECI: begin
                alu_src_a_reg   <= 2'b10;
                alu_src_b_reg   <= 2'b01;
                alu_control_reg <= i_alu_next;
            end
            S_ALUWB: begin
                reg_write_reg  <= 1'b1;
                instr_done_reg <= 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_reg   <= 2'b10;
                alu_control_reg <= ALU_SUB;
                branch_reg      <= 1'b1;
                instr_done_reg  <= 1'b1;
            end
            S_JAL: begin
                alu_src_a_reg <= 2'b01;
                alu_src_b_reg <= 2'b10;
                pc_write_reg  <= 1'b1;
            end
            default: ;
        endcase
    end

    // Branch outcome depends on this cycle's zero flag, so it cannot be registered ahead.
    assign ctrl.pc_write    = (pc_write_reg | (branch_reg & (ctrl.zero ^ ctrl.funct3[0]))) & ~reset;
    assign ctrl.ir_write    = ir_write_reg & ~reset;
    assign ctrl.mem_write   = mem_write_reg & ~reset;
    assign ctrl.reg_write   = reg_write_reg & ~reset;
    assign ctrl.instr_done  = instr_done_reg & ~reset;
    assign ctrl.illegal     = (state_reg == S_DECODE) & decode_illegal_next & ~reset;
    assign ctrl.adr_src     = adr_src_reg;
    assign ctrl.result_src  = result_src_reg;
    assign ctrl.alu_src_a   = alu_src_a_reg;
    assign ctrl.alu_src_b   = alu_src_b_reg;
    assign ctrl.alu_control = alu_control_reg;

    always_comb begin
        case (ctrl.op)
            OP_SW:   ctrl.imm_src = 2'b01;
            OP_BR:   ctrl.imm_src = 2'b10;
            OP_JAL:  ctrl.imm_src = 2'b11;
            default: ctrl.imm_src = 2'b00;
        endcase
    end
endmodule
